tap_tms_driver: RTL and testbench

JTAG TAP initiator that drives TMS_Pad into a TAP controller sharing GCLK_Pad. It keeps an internal mirror of the target's 16-state TAP FSM, and its model output uses the same 4-bit encoding the TAP exposes on its state_obs pads. A host command names a stable destination state and an optional dwell count. The block walks the TAP there along a fixed deterministic path, dwells, and signals done.

---
 rtl/tap_tms_driver.sv | 203 ++++++++++++++++++++
 tb/tb_tap_tms_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tap_tms_driver.sv
// JTAG TAP initiator: mirrors the target TAP FSM and drives a registered TMS
// along a fixed path to a stable state, dwells there, then pulses done.
// Ports: GCLK_Pad/RSTN_Pad clock and async active-low reset; cmd_valid,
//   cmd_ready, cmd_target, cmd_hold command handshake; TMS_Pad to the TAP;
//   state_model mirrored state; busy, done, cmd_err status.
// Optional: define TAP_TRST_EN to add TRST_Pad, which resets the TAP for TLR targets.
module tap_tms_driver #(
  parameter int HOLD_W = 8
) (
  input  logic              GCLK_Pad,
  input  logic              RSTN_Pad,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_target,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              TMS_Pad,
  output logic [3:0]        state_model,
  output logic              busy,
  output logic              done,
  output logic              cmd_err
`ifdef TAP_TRST_EN
  ,
  output logic              TRST_Pad
`endif
);

  localparam logic [3:0] TLR   = 4'hF;
  localparam logic [3:0] RTI   = 4'hC;
  localparam logic [3:0] SELDR = 4'h7;
  localparam logic [3:0] CAPDR = 4'h6;
  localparam logic [3:0] SHDR  = 4'h2;
  localparam logic [3:0] EX1DR = 4'h1;
  localparam logic [3:0] PAUDR = 4'h3;
  localparam logic [3:0] EX2DR = 4'h0;
  localparam logic [3:0] UPDDR = 4'h5;
  localparam logic [3:0] SELIR = 4'h4;
  localparam logic [3:0] CAPIR = 4'hE;
  localparam logic [3:0] SHIR  = 4'hA;
  localparam logic [3:0] EX1IR = 4'h9;
  localparam logic [3:0] PAUIR = 4'hB;
  localparam logic [3:0] EX2IR = 4'h8;
  localparam logic [3:0] UPDIR = 4'hD;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WALK  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  function automatic logic [3:0] tap_next(
    input logic [3:0] s,
    input logic       t
  );
    logic [3:0] n;
    case (s)
      TLR:     n = t ? TLR   : RTI;
      RTI:     n = t ? SELDR : RTI;
      SELDR:   n = t ? SELIR : CAPDR;
      CAPDR:   n = t ? EX1DR : SHDR;
      SHDR:    n = t ? EX1DR : SHDR;
      EX1DR:   n = t ? UPDDR : PAUDR;
      PAUDR:   n = t ? EX2DR : PAUDR;
      EX2DR:   n = t ? UPDDR : SHDR;
      UPDDR:   n = t ? SELDR : RTI;
      SELIR:   n = t ? TLR   : CAPIR;
      CAPIR:   n = t ? EX1IR : SHIR;
      SHIR:    n = t ? EX1IR : SHIR;
      EX1IR:   n = t ? UPDIR : PAUIR;
      PAUIR:   n = t ? EX2IR : PAUIR;
      EX2IR:   n = t ? UPDIR : SHIR;
      UPDIR:   n = t ? SELDR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

  // Column-relative codes: bit 3 picks IR vs DR for capture/exit states.
  function automatic logic route(
    input logic [3:0] s,
    input logic [3:0] g
  );
    logic r;
    logic in_dr;
    in_dr = !g[3] && (g != SELIR);
    r = 1'b1;
    if (g == TLR) begin
      r = 1'b1;
    end else begin
      case (s)
        TLR:          r = 1'b0;
        RTI:          r = 1'b1;
        SELDR:        r = !in_dr;
        SELIR:        r = 1'b0;
        CAPDR, CAPIR: r = (g != {s[3], 3'b010});
        SHDR, SHIR:   r = 1'b1;
        EX1DR, EX1IR: r = (g != {s[3], 3'b011});
        PAUDR, PAUIR: r = 1'b1;
        EX2DR, EX2IR: r = (g != {s[3], 3'b010});
        UPDDR, UPDIR: r = (g != RTI);
        default:      r = 1'b1;
      endcase
    end
    return r;
  endfunction

  logic [1:0]        fsm, fsm_n;
  logic [3:0]        target, tgt_n;
  logic [HOLD_W-1:0] hold, hold_s;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic [3:0]        model_n;
  logic              tms_n;
  logic              done_n;
  logic              legal;
  logic              accept;
  logic              reject;
  logic              trst_go;

  assign cmd_ready = (fsm == S_IDLE);
  assign busy      = (fsm != S_IDLE);

  always_comb begin
    model_n = tap_next(state_model, TMS_Pad);
`ifdef TAP_TRST_EN
    if (TRST_Pad) model_n = TLR;
`endif
    legal = (cmd_target == TLR) || (cmd_target == RTI) ||
            (cmd_target == SHDR) || (cmd_target == PAUDR) ||
            (cmd_target == SHIR) || (cmd_target == PAUIR);
    accept = cmd_valid && cmd_ready && legal;
    reject = cmd_valid && cmd_ready && !legal;
    tgt_n  = accept ? cmd_target : target;
    hold_s = accept ? cmd_hold : hold;
`ifdef TAP_TRST_EN
    trst_go = accept && (cmd_target == TLR) && (model_n != TLR);
`else
    trst_go = 1'b0;
`endif
    fsm_n  = fsm;
    cnt_n  = cnt;
    done_n = 1'b0;
    case (fsm)
      S_IDLE, S_WALK: begin
        if (fsm == S_WALK || accept) begin
          if (trst_go) begin
            fsm_n = S_WALK;
          end else if (model_n == tgt_n) begin
            if (hold_s != '0) begin
              fsm_n = S_DWELL;
              cnt_n = hold_s;
            end else begin
              fsm_n  = S_IDLE;
              done_n = 1'b1;
            end
          end else begin
            fsm_n = S_WALK;
          end
        end
      end
      S_DWELL: begin
        if (cnt <= HOLD_W'(1)) begin
          fsm_n  = S_IDLE;
          done_n = 1'b1;
          cnt_n  = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: fsm_n = S_IDLE;
    endcase
    // Parked states hold via their self-loop bit; only a walk follows the route.
    tms_n = (fsm_n == S_WALK) ? route(model_n, tgt_n) : (model_n == TLR);
  end

  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad) begin
    if (!RSTN_Pad) begin
      fsm         <= S_IDLE;
      target      <= TLR;
      hold        <= '0;
      cnt         <= '0;
      state_model <= TLR;
      TMS_Pad     <= 1'b1;
      done        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      fsm         <= fsm_n;
      cnt         <= cnt_n;
      state_model <= model_n;
      TMS_Pad     <= tms_n;
      done        <= done_n;
      cmd_err     <= reject;
      if (accept) begin
        target <= cmd_target;
        hold   <= cmd_hold;
      end
    end
  end

`ifdef TAP_TRST_EN
  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad) begin
    if (!RSTN_Pad) TRST_Pad <= 1'b0;
    else           TRST_Pad <= trst_go;
  end
`endif

endmodule

// File: tb/tb_tap_tms_driver.sv
// Directed bench for tap_tms_driver: per-cycle expectations are queued
// as commands are issued and compared after each rising edge.
module tb_tap_tms_driver;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_target;
  logic [7:0] cmd_hold;
  logic       tms;
  logic [3:0] model;
  logic       busy;
  logic       done;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       tms;
    logic [3:0] model;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t sb[$];

  tap_tms_driver #(.HOLD_W(8)) dut (
    .GCLK_Pad    (clk),
    .RSTN_Pad    (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .cmd_hold    (cmd_hold),
    .TMS_Pad     (tms),
    .state_model (model),
    .busy        (busy),
    .done        (done),
    .cmd_err     (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ex(input logic t, input logic [3:0] m, input logic b,
                    input logic d, input logic e);
    exp_t x;
    x.tms = t; x.model = m; x.busy = b; x.done = d; x.err = e;
    sb.push_back(x);
  endtask

  task automatic issue(input logic [3:0] t, input logic [7:0] h);
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_hold   = h;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 8'd1, 8'd0);
        return;
      end
      x = sb.pop_front();
      chk("tms", {7'd0, tms}, {7'd0, x.tms});
      chk("model", {4'd0, model}, {4'd0, x.model});
      chk("busy", {7'd0, busy}, {7'd0, x.busy});
      chk("done", {7'd0, done}, {7'd0, x.done});
      chk("cmd_err", {7'd0, cmd_err}, {7'd0, x.err});
      chk("ready", {7'd0, cmd_ready}, {7'd0, !x.busy});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain_all();
    drain(sb.size());
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tms"}, {7'd0, tms}, 8'd1);
    chk({tag, "_model"}, {4'd0, model}, 8'h0F);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_done"}, {7'd0, done}, 8'd0);
    chk({tag, "_err"}, {7'd0, cmd_err}, 8'd0);
    chk({tag, "_ready"}, {7'd0, cmd_ready}, 8'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = 4'h0;
    cmd_hold   = 8'd0;
    #12;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // idle after reset: parked in TLR with TMS high
    for (int i = 0; i < 10; i++) ex(1, 4'hF, 0, 0, 0);
    drain_all();

    // TLR -> ShiftDR, no dwell
    ex(0, 4'hF, 1, 0, 0); ex(1, 4'hC, 1, 0, 0); ex(0, 4'h7, 1, 0, 0);
    ex(0, 4'h6, 1, 0, 0); ex(0, 4'h2, 0, 1, 0); ex(0, 4'h2, 0, 0, 0);
    ex(0, 4'h2, 0, 0, 0);
    issue(4'h2, 8'd0);
    drain_all();

    // ShiftDR -> PauseIR, dwell 3
    ex(1, 4'h2, 1, 0, 0); ex(1, 4'h1, 1, 0, 0); ex(1, 4'h5, 1, 0, 0);
    ex(1, 4'h7, 1, 0, 0); ex(0, 4'h4, 1, 0, 0); ex(1, 4'hE, 1, 0, 0);
    ex(0, 4'h9, 1, 0, 0); ex(0, 4'hB, 1, 0, 0); ex(0, 4'hB, 1, 0, 0);
    ex(0, 4'hB, 1, 0, 0); ex(0, 4'hB, 0, 1, 0); ex(0, 4'hB, 0, 0, 0);
    issue(4'hB, 8'd3);
    drain_all();

    // PauseIR -> PauseDR
    ex(1, 4'hB, 1, 0, 0); ex(1, 4'h8, 1, 0, 0); ex(1, 4'hD, 1, 0, 0);
    ex(0, 4'h7, 1, 0, 0); ex(1, 4'h6, 1, 0, 0); ex(0, 4'h1, 1, 0, 0);
    ex(0, 4'h3, 0, 1, 0); ex(0, 4'h3, 0, 0, 0);
    issue(4'h3, 8'd0);
    drain_all();

    // PauseDR -> ShiftDR via Exit2
    ex(1, 4'h3, 1, 0, 0); ex(0, 4'h0, 1, 0, 0);
    ex(0, 4'h2, 0, 1, 0); ex(0, 4'h2, 0, 0, 0);
    issue(4'h2, 8'd0);
    drain_all();

    // unstable target rejected
    ex(0, 4'h2, 0, 0, 1); ex(0, 4'h2, 0, 0, 0);
    issue(4'h6, 8'd0);
    drain_all();

    // ShiftDR -> RTI with a new request held while busy (ignored)
    ex(1, 4'h2, 1, 0, 0); ex(1, 4'h1, 1, 0, 0); ex(0, 4'h5, 1, 0, 0);
    ex(0, 4'hC, 0, 1, 0); ex(0, 4'hC, 0, 0, 0); ex(0, 4'hC, 0, 0, 0);
    issue(4'hC, 8'd0);
    cmd_valid  = 1'b1;
    cmd_target = 4'hA;
    drain(2);
    cmd_valid = 1'b0;
    drain_all();

    // reset mid-walk toward ShiftIR
    ex(1, 4'hC, 1, 0, 0); ex(1, 4'h7, 1, 0, 0);
    issue(4'hA, 8'd0);
    drain(2);
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    repeat (3) @(posedge clk);
    #1;
    chk_reset("abort_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // re-issue TLR -> ShiftIR
    ex(0, 4'hF, 1, 0, 0); ex(1, 4'hC, 1, 0, 0); ex(1, 4'h7, 1, 0, 0);
    ex(0, 4'h4, 1, 0, 0); ex(0, 4'hE, 1, 0, 0); ex(0, 4'hA, 0, 1, 0);
    ex(0, 4'hA, 0, 0, 0);
    issue(4'hA, 8'd0);
    drain_all();

    // ShiftIR -> RTI
    ex(1, 4'hA, 1, 0, 0); ex(1, 4'h9, 1, 0, 0); ex(0, 4'hD, 1, 0, 0);
    ex(0, 4'hC, 0, 1, 0); ex(0, 4'hC, 0, 0, 0);
    issue(4'hC, 8'd0);
    drain_all();

    // RTI -> TLR by TMS walk, dwell 2
    ex(1, 4'hC, 1, 0, 0); ex(1, 4'h7, 1, 0, 0); ex(1, 4'h4, 1, 0, 0);
    ex(1, 4'hF, 1, 0, 0); ex(1, 4'hF, 1, 0, 0); ex(1, 4'hF, 0, 1, 0);
    ex(1, 4'hF, 0, 0, 0);
    issue(4'hF, 8'd2);
    drain_all();

    // target equals current state: immediate done
    ex(1, 4'hF, 0, 1, 0); ex(1, 4'hF, 0, 0, 0);
    issue(4'hF, 8'd0);
    drain_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
